// File: rtl/ms7_master_driver_pkg.sv
// Shared types for the MS7 master driver: FSM section encoding and counter widths.
package ms7_master_driver_types;

    localparam int WORD_CNT_W = 8;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        SEC_IDLE,
        SEC_SEND,
        SEC_WAIT,
        SEC_CAPTURE
    } Sections;

endpackage

// File: rtl/ms7_master_driver.sv
// Stimulus/response master for the MS7 slave: sends a burst of words, samples replies after LATENCY.
// Build option MS7_ACCUM_EN: result is the wrapping sum of all replies instead of the last reply.
module ms7_master_driver
    import ms7_master_driver_types::*;
#(
    parameter int NUM_WORDS = 4,
    parameter int STEP      = 1,
    parameter int LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] seed,
    input  logic [31:0] m_in,
    output logic [31:0] m_out,
    output logic        m_out_sync,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        busy
);

`ifdef MS7_ACCUM_EN
    localparam bit ACCUM_EN = 1'b1;
`else
    localparam bit ACCUM_EN = 1'b0;
`endif

    Sections                 state_q;
    logic [31:0]             val_q;
    logic [WORD_CNT_W-1:0]   word_cnt_q;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q;
    logic [31:0]             acc_q;
    logic [31:0]             m_out_q;
    logic                    m_out_sync_q;
    logic [31:0]             result_q;
    logic                    result_valid_q;
    logic                    busy_q;

    logic [31:0]             acc_d;
    logic [31:0]             val_d;
    logic [WORD_CNT_W-1:0]   word_cnt_d;
    logic                    last_word;

    // Capture-cycle datapath; only committed while in SEC_CAPTURE.
    always_comb begin
        acc_d      = ACCUM_EN ? (acc_q + m_in) : m_in;
        val_d      = val_q + 32'(STEP);
        word_cnt_d = word_cnt_q + 1'b1;
        last_word  = (word_cnt_d == WORD_CNT_W'(NUM_WORDS));
    end

    // The word and its strobe are registered on entry to SEC_SEND so that
    // m_out_sync is high exactly during the SEND cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= SEC_IDLE;
            val_q          <= '0;
            word_cnt_q     <= '0;
            wait_cnt_q     <= '0;
            acc_q          <= '0;
            m_out_q        <= '0;
            m_out_sync_q   <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            m_out_sync_q   <= 1'b0;
            result_valid_q <= 1'b0;
            case (state_q)
                SEC_IDLE: begin
                    if (start) begin
                        val_q        <= seed;
                        word_cnt_q   <= '0;
                        acc_q        <= '0;
                        m_out_q      <= seed;
                        m_out_sync_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= SEC_SEND;
                    end
                end
                SEC_SEND: begin
                    wait_cnt_q <= WAIT_CNT_W'(LATENCY - 1);
                    state_q    <= SEC_WAIT;
                end
                SEC_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        state_q <= SEC_CAPTURE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                SEC_CAPTURE: begin
                    acc_q      <= acc_d;
                    val_q      <= val_d;
                    word_cnt_q <= word_cnt_d;
                    if (last_word) begin
                        result_q       <= acc_d;
                        result_valid_q <= 1'b1;
                        busy_q         <= 1'b0;
                        state_q        <= SEC_IDLE;
                    end else begin
                        m_out_q      <= val_d;
                        m_out_sync_q <= 1'b1;
                        state_q      <= SEC_SEND;
                    end
                end
                default: state_q <= SEC_IDLE;
            endcase
        end
    end

    assign m_out        = m_out_q;
    assign m_out_sync   = m_out_sync_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;

endmodule
